// File: rtl/mmac_pkg.sv
// Shared sizing for the matrix multiply-accumulate datapath.
package mmac_pkg;
  parameter int unsigned DATA_WIDTH = 32;
  parameter int unsigned VAR_WIDTH  = 8;
endpackage

// File: rtl/mmac_sequencer.sv
// Job-level controller: feeds operand pairs to the multiply unit, waits for the product to
// settle, accumulates lane-wise and presents the accumulated matrix on a valid/ready port.
module mmac_sequencer #(
  parameter int unsigned DATA_WIDTH = mmac_pkg::DATA_WIDTH,
  parameter int unsigned VAR_WIDTH  = mmac_pkg::VAR_WIDTH,
  parameter int unsigned MUL_LAT    = 1,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  abort,
  input  logic                  start_valid,
  output logic                  start_ready,
  input  logic [CNT_WIDTH-1:0]  start_count,
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  output logic [DATA_WIDTH-1:0] mul_a,
  output logic [DATA_WIDTH-1:0] mul_b,
  input  logic [DATA_WIDTH-1:0] mul_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  remaining
);

  localparam int unsigned Lanes = DATA_WIDTH / VAR_WIDTH;
  localparam int unsigned WaitW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [WaitW-1:0] WaitInit = WaitW'(MUL_LAT - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StWait, StAcc, StDone} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d, acc_sum;
  logic [CNT_WIDTH-1:0]  remaining_q, remaining_d;
  logic [DATA_WIDTH-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic [WaitW-1:0]      wait_q, wait_d;

  // Per-lane modulo add; lanes never carry into each other.
  always_comb begin
    acc_sum = '0;
    for (int l = 0; l < Lanes; l++) begin
      acc_sum[l*VAR_WIDTH +: VAR_WIDTH] = acc_q[l*VAR_WIDTH +: VAR_WIDTH]
                                        + mul_result[l*VAR_WIDTH +: VAR_WIDTH];
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    remaining_d = remaining_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    wait_d      = wait_q;
    start_ready = 1'b0;
    op_ready    = 1'b0;
    out_valid   = 1'b0;

    unique case (state_q)
      StIdle: begin
        start_ready = 1'b1;
        if (start_valid) begin
          acc_d       = '0;
          remaining_d = start_count;
          state_d     = (start_count == '0) ? StDone : StLoad;
        end
      end
      StLoad: begin
        op_ready = 1'b1;
        if (op_valid) begin
          mul_a_d = op_a;
          mul_b_d = op_b;
          wait_d  = WaitInit;
          state_d = StWait;
        end
      end
      StWait: begin
        if (wait_q == '0) begin
          state_d = StAcc;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      StAcc: begin
        acc_d       = acc_sum;
        remaining_d = remaining_q - 1'b1;
        state_d     = (remaining_d == '0) ? StDone : StLoad;
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // A handshake in the abort cycle is consumed but leaves no trace.
    if (abort) begin
      state_d     = StIdle;
      acc_d       = '0;
      remaining_d = '0;
      mul_a_d     = mul_a_q;
      mul_b_d     = mul_b_q;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      remaining_q <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      wait_q      <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      remaining_q <= remaining_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      wait_q      <= wait_d;
    end
  end

  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign out_data  = acc_q;
  assign remaining = remaining_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_mmac_sequencer.sv
// Self-checking bench for mmac_sequencer: directed job scenarios plus randomized traffic,
// checked every cycle against a transaction-level model with a 2x2 matrix multiply unit.
module tb_mmac_sequencer;

  localparam int unsigned DW = mmac_pkg::DATA_WIDTH;
  localparam int unsigned VW = mmac_pkg::VAR_WIDTH;
  localparam int unsigned ML = 1;
  localparam int unsigned CW = 8;
  localparam logic [DW-1:0] Ident = 32'h0100_0001;

  logic          clock = 1'b0;
  logic          reset, abort, start_valid, start_ready, op_valid, op_ready;
  logic [CW-1:0] start_count, remaining;
  logic [DW-1:0] op_a, op_b, mul_a, mul_b, mul_result, out_data;
  logic          out_valid, out_ready, busy;

  int n_cmp = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;

  mmac_sequencer #(
    .DATA_WIDTH(DW),
    .VAR_WIDTH (VW),
    .MUL_LAT   (ML),
    .CNT_WIDTH (CW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .abort      (abort),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .start_count(start_count),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_a       (op_a),
    .op_b       (op_b),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_result (mul_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy),
    .remaining  (remaining)
  );

  always #5 clock = ~clock;

  // 2x2 matrix product, element (i,j) in lane i*2+j, modulo 2^VW.
  function automatic logic [DW-1:0] matmul(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] c;
    logic [VW-1:0] s;
    c = '0;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        s = '0;
        for (int k = 0; k < 2; k++) begin
          s = s + a[(i*2+k)*VW +: VW] * b[(k*2+j)*VW +: VW];
        end
        c[(i*2+j)*VW +: VW] = s;
      end
    end
    return c;
  endfunction

  function automatic logic [DW-1:0] lane_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] c;
    c = '0;
    for (int l = 0; l < 4; l++) c[l*VW +: VW] = a[l*VW +: VW] + b[l*VW +: VW];
    return c;
  endfunction

  assign mul_result = matmul(mul_a, mul_b);

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Transaction-level model: job in progress, awaiting operand, accumulate due at a cycle.
  int            cyc = 0;
  int            m_due;
  logic          m_job, m_ld, m_done;
  logic [CW-1:0] m_left;
  logic [DW-1:0] m_acc, m_prod, m_ma, m_mb;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (!reset) begin
      m_job <= 1'b0; m_ld <= 1'b0; m_done <= 1'b0;
      m_left <= '0; m_acc <= '0; m_ma <= '0; m_mb <= '0;
    end else if (abort) begin
      m_job <= 1'b0; m_ld <= 1'b0; m_done <= 1'b0;
      m_left <= '0; m_acc <= '0;
    end else if (!m_job && !m_done) begin
      if (start_valid) begin
        m_acc  <= '0;
        m_left <= start_count;
        if (start_count == 0) m_done <= 1'b1;
        else begin m_job <= 1'b1; m_ld <= 1'b1; end
      end
    end else if (m_job && m_ld) begin
      if (op_valid) begin
        m_ma   <= op_a;
        m_mb   <= op_b;
        m_prod <= matmul(op_a, op_b);
        m_ld   <= 1'b0;
        m_due  <= cyc + ML + 1;
      end
    end else if (m_job && cyc == m_due) begin
      m_acc  <= lane_add(m_acc, m_prod);
      m_left <= m_left - 1'b1;
      if (m_left == 1) begin m_job <= 1'b0; m_done <= 1'b1; end
      else m_ld <= 1'b1;
    end else if (m_done && out_ready) begin
      m_done <= 1'b0;
    end
  end

  always @(posedge clock) begin
    #1;
    if (chk_en) begin
      chk("start_ready", start_ready, !m_job && !m_done);
      chk("op_ready", op_ready, m_job && m_ld);
      chk("out_valid", out_valid, m_done);
      chk("busy", busy, m_job || m_done);
      chk("remaining", remaining, m_left);
      chk("mul_a", mul_a, m_ma);
      chk("mul_b", mul_b, m_mb);
      if (m_done) chk("out_data", out_data, m_acc);
    end
  end

  // Operands held valid throughout; returns result and start-to-out_valid latency.
  task automatic do_job(input int n, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        output logic [DW-1:0] res, output int lat);
    start_valid = 1'b1; start_count = CW'(n);
    op_valid = 1'b1; op_a = a; op_b = b;
    tick();
    start_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    if (!out_valid) chk("job_timeout", 32'd0, 32'd1);
    res = out_data;
    op_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("busy_after_out", busy, 1'b0);
  endtask

  logic [DW-1:0] res;
  int            lat;

  initial begin
    reset = 1'b0; abort = 1'b0; start_valid = 1'b0; start_count = '0;
    op_valid = 1'b0; op_a = '0; op_b = '0; out_ready = 1'b0;
    repeat (2) tick();
    chk_en = 1'b1;
    chk("rst_start_ready", start_ready, 1'b1);
    chk("rst_op_ready", op_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_mul_a", mul_a, 32'h0);
    reset = 1'b1;
    tick();

    do_job(1, Ident, 32'h0303_0303, res, lat);
    chk("n1_data", res, 32'h0303_0303);
    chk("n1_latency", lat, 32'd4);

    do_job(3, Ident, 32'h0202_0202, res, lat);
    chk("n3_data", res, 32'h0606_0606);
    chk("n3_latency", lat, 32'd10);

    do_job(2, Ident, 32'h0102_0380, res, lat);
    chk("wrap_data", res, 32'h0204_0600);

    // Zero-length job, output stalled.
    start_valid = 1'b1; start_count = '0;
    tick();
    start_valid = 1'b0;
    chk("n0_out_valid", out_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("n0_hold_data", out_data, 32'h0);
      chk("n0_hold_start_ready", start_ready, 1'b0);
      tick();
    end
    chk("n0_still_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("n0_back_idle", start_ready, 1'b1);

    // Stray operands in IDLE.
    op_valid = 1'b1; op_a = 32'hdead_beef;
    repeat (3) begin
      tick();
      chk("idle_op_ready", op_ready, 1'b0);
    end
    op_valid = 1'b0;

    // Abort during WAIT of the second of three pairs.
    start_valid = 1'b1; start_count = 8'd3;
    op_valid = 1'b1; op_a = Ident; op_b = 32'h0202_0202;
    tick();
    start_valid = 1'b0;
    repeat (4) tick();
    chk("abort_pre_remaining", remaining, 8'd2);
    abort = 1'b1;
    tick();
    abort = 1'b0; op_valid = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_remaining", remaining, 8'd0);
    repeat (3) begin
      tick();
      chk("abort_no_out", out_valid, 1'b0);
    end
    do_job(1, Ident, 32'h0505_0505, res, lat);
    chk("post_abort_data", res, 32'h0505_0505);

    // Reset hitting DONE together with out_ready.
    start_valid = 1'b1; start_count = 8'd1;
    op_valid = 1'b1; op_a = Ident; op_b = 32'h0909_0909;
    tick();
    start_valid = 1'b0;
    for (int i = 0; i < 20 && !out_valid; i++) tick();
    chk("pre_reset_out_valid", out_valid, 1'b1);
    op_valid = 1'b0; out_ready = 1'b1; reset = 1'b0;
    tick();
    chk("rr_start_ready", start_ready, 1'b1);
    chk("rr_out_valid", out_valid, 1'b0);
    chk("rr_busy", busy, 1'b0);
    chk("rr_out_data", out_data, 32'h0);
    chk("rr_mul_b", mul_b, 32'h0);
    chk("rr_remaining", remaining, 8'd0);
    reset = 1'b1; out_ready = 1'b0;
    tick();

    // Randomized traffic including stray aborts and resets.
    for (int i = 0; i < 3000; i++) begin
      start_valid = 1'($urandom_range(0, 1));
      start_count = CW'($urandom_range(0, 4));
      op_valid    = ($urandom_range(0, 2) != 0);
      op_a        = $urandom;
      op_b        = $urandom;
      out_ready   = 1'($urandom_range(0, 1));
      abort       = ($urandom_range(0, 79) == 0);
      reset       = ($urandom_range(0, 399) != 0);
      tick();
    end
    reset = 1'b1; abort = 1'b0; start_valid = 1'b0; op_valid = 1'b0; out_ready = 1'b1;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mmac_sequencer.md
# mmac_sequencer

Job-level controller for the matrix multiply datapath. It accepts a job of N operand-matrix pairs over valid/ready handshakes and feeds each pair to `matrix_multiply_unit` through registered `mul_a`/`mul_b`. It waits a fixed settle latency, then accumulates `mul_result` lane-wise into an internal accumulator. When the job completes it presents the accumulated matrix on a valid/ready output port. It sits between the command/DMA front-end and the multiply unit, and replaces ad-hoc clear/enable driving of the accumulate stage.

## Interface
Parameters (`DATA_WIDTH` and `VAR_WIDTH` are taken from `mmac_pkg`):
- `DATA_WIDTH`, pkg value: packed matrix width.
- `VAR_WIDTH`, pkg value: element width. Lanes = `DATA_WIDTH/VAR_WIDTH`; lane 0 = bits `[VAR_WIDTH-1:0]`.
- `MUL_LAT`, 1: cycles `mul_result` needs to settle after `mul_a`/`mul_b` update. Legal range ≥1.
- `CNT_WIDTH`, 8: width of the pair count.

Ports:
- `clock` in 1: single clock, all logic on rising edge.
- `reset` in 1: synchronous, active-low.
- `abort` in 1: cancel the current job.
- `start_valid` in 1; `start_ready` out 1; `start_count` in `CNT_WIDTH`: number of pairs N in the job.
- `op_valid` in 1; `op_ready` out 1; `op_a`, `op_b` in `DATA_WIDTH`: operand pair.
- `mul_a`, `mul_b` out `DATA_WIDTH`: registered operands to the multiply unit.
- `mul_result` in `DATA_WIDTH`: product from the multiply unit.
- `out_valid` out 1; `out_ready` in 1; `out_data` out `DATA_WIDTH`: accumulated result.
- `busy` out 1: high in any state except IDLE.
- `remaining` out `CNT_WIDTH`: pairs not yet accumulated.

## Operation
- States: IDLE, LOAD, WAIT, ACC, DONE.
- IDLE: `start_ready`=1. On `start_valid`&&`start_ready`:
  - accumulator := 0; `remaining` := `start_count`.
  - Go to DONE if `start_count`==0, else LOAD.
- LOAD: `op_ready`=1. On `op_valid`&&`op_ready`:
  - `mul_a` := `op_a`, `mul_b` := `op_b`.
  - Wait counter := `MUL_LAT`-1; go to WAIT.
- WAIT: count down each cycle; go to ACC the cycle after the counter reads 0.
- ACC (one cycle):
  - Each lane: acc[lane] := acc[lane] + `mul_result`[lane], modulo 2^`VAR_WIDTH`. No carry between lanes, no saturation.
  - `remaining` := `remaining`-1. Go to DONE if the new value is 0, else LOAD.
- DONE: `out_valid`=1, `out_data`=accumulator, held stable until `out_ready`; then go to IDLE.
- `start_ready`/`op_ready` are decoded from state only. Never assert them outside IDLE/LOAD.
- `abort` (priority below reset, above everything else):
  - Next state IDLE; accumulator and `remaining` := 0; `out_valid` drops next cycle.
  - A start, operand or output handshake completing in the same cycle as `abort` counts as transferred but has no further effect.
- `start_valid` while not IDLE is ignored (not acknowledged). `op_valid` outside LOAD is ignored.
- `mul_a`/`mul_b` hold their last values outside LOAD handshakes.

## Timing
- Reset values (cycle after `reset`=0 sampled):
  - state IDLE; `start_ready`=1; `op_ready`=0; `out_valid`=0; `busy`=0.
  - `out_data`, `mul_a`, `mul_b`, `remaining`, accumulator all 0.
- Reset mid-job discards all progress; there is no pending output after reset.
- Start accepted at edge t: LOAD at t+1, and `op_ready`=1 in cycle t+1.
- Per pair: LOAD handshake edge → `MUL_LAT` WAIT cycles → 1 ACC cycle → LOAD. With `op_valid` held high, throughput is one pair per `MUL_LAT`+2 cycles.
- Job latency, start handshake to `out_valid`, with operands always valid: 1 + N·(`MUL_LAT`+2) cycles. For N=0, `out_valid` is asserted the cycle after the start handshake.
- Output handshake at edge t: IDLE at t+1, so `start_ready`=1 at t+1. Minimum one-cycle gap between jobs.

## Test plan
- Reset, then MUL_LAT=1, N=1, A=identity, B=all lanes 3 → `out_valid` 4 cycles after start handshake, `out_data` all lanes 3; `busy` deasserts after the out handshake.
- N=3 with identical pairs, A=identity, B=all lanes 2 → every lane 6. `remaining` reads 3,2,1,0 across the ACC edges.
- Wrap: VAR_WIDTH lane holding max value, N=2, each product lane = 2^(VAR_WIDTH-1) → lane result 0, and adjacent lanes are unaffected (no carry).
- N=0 → `out_valid` next cycle, `out_data`=0. Hold `out_ready`=0 for 5 cycles → data stable and `start_ready`=0 throughout.
- `abort` in WAIT of the 2nd of 3 pairs → IDLE next cycle, no `out_valid`. A following N=1 job returns only its own product, proving the accumulator was cleared.
- Assert `reset` in DONE with `out_ready`=1 in the same cycle → all outputs at reset values next cycle. Extra `op_valid` pulses in IDLE/WAIT are never acknowledged.
